// File: rtl/cci_mpf_prim_write_packet_buffer.sv
// rtl/cci_mpf_prim_write_packet_buffer.sv - store-and-forward C1 TX buffer releasing whole write packets.
// Optional checks: CCI_MPF_PRIM_WRITE_PACKET_BUFFER_CHECK_EN.

package cci_mpf_prim_write_packet_buffer_pkg;
  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int CCI_CLDATA_WIDTH = 64;

  typedef logic [1:0]                  t_cci_clNum;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_cci_c1_req;

  typedef struct packed {
    t_cci_c1_req req_type;
    logic        sop;
    t_cci_clNum  cl_len;
    t_cci_clAddr address;
  } t_cci_mpf_c1_ReqHdrBase;

  typedef struct packed {
    t_cci_mpf_c1_ReqHdrBase base;
  } t_cci_mpf_c1_ReqHdr;

  typedef struct packed {
    t_cci_mpf_c1_ReqHdr hdr;
    t_cci_clData        data;
    logic               valid;
  } t_if_cci_mpf_c1_Tx;

  function automatic logic cci_c1_is_write(input t_cci_c1_req r);
    return (r == eREQ_WRLINE_I) || (r == eREQ_WRLINE_M) || (r == eREQ_WRPUSH_I);
  endfunction
endpackage

module cci_mpf_prim_write_packet_buffer
  import cci_mpf_prim_write_packet_buffer_pkg::*;
#(
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  t_if_cci_mpf_c1_Tx          c1Tx_in,
  output logic                       c1Tx_in_almostFull,
  output t_if_cci_mpf_c1_Tx          c1Tx_out,
  input  logic                       c1Tx_out_deq,
  output logic [$clog2(DEPTH):0]     packetsReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  t_if_cci_mpf_c1_Tx mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] packets_ready_q, packets_ready_d;
  logic [CW-1:0] free_d;
  t_cci_clNum    in_beat_q, in_beat_d;
  t_cci_clNum    out_beat_q, out_beat_d;
  logic          out_active_q, out_active_d;
  logic          almost_full_q, almost_full_d;

  t_if_cci_mpf_c1_Tx head;
  logic full, out_valid, enq, deq;
  logic in_is_write, in_completes, head_is_write, deq_start;

  assign head          = mem_q[rd_ptr_q];
  assign full          = (count_q == CW'(DEPTH));
  assign out_valid     = (count_q != '0) && (out_active_q || (packets_ready_q != '0));
  assign deq           = c1Tx_out_deq && out_valid;
  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign enq           = c1Tx_in.valid && (!full || deq);
  assign in_is_write   = cci_c1_is_write(c1Tx_in.hdr.base.req_type);
  assign in_completes  = enq && (!in_is_write || (in_beat_q == c1Tx_in.hdr.base.cl_len));
  assign head_is_write = cci_c1_is_write(head.hdr.base.req_type);
  assign deq_start     = deq && (!head_is_write || head.hdr.base.sop);

  always_comb begin
    wr_ptr_d        = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d        = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d         = count_q + CW'(enq) - CW'(deq);
    packets_ready_d = packets_ready_q + CW'(in_completes) - CW'(deq_start);
    free_d          = CW'(DEPTH) - count_d;
    almost_full_d   = (free_d <= CW'(ALMOST_FULL_THRESHOLD));

    in_beat_d = in_beat_q;
    if (enq && in_is_write) begin
      in_beat_d = in_completes ? '0 : in_beat_q + 2'd1;
    end

    out_beat_d   = out_beat_q;
    out_active_d = out_active_q;
    if (deq && head_is_write) begin
      if (out_beat_q == head.hdr.base.cl_len) begin
        out_beat_d   = '0;
        out_active_d = 1'b0;
      end else begin
        out_beat_d   = out_beat_q + 2'd1;
        out_active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      packets_ready_q <= '0;
      in_beat_q       <= '0;
      out_beat_q      <= '0;
      out_active_q    <= 1'b0;
      almost_full_q   <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      packets_ready_q <= packets_ready_d;
      in_beat_q       <= in_beat_d;
      out_beat_q      <= out_beat_d;
      out_active_q    <= out_active_d;
      almost_full_q   <= almost_full_d;
    end
  end

  // Payload storage needs no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= c1Tx_in;
    end
  end

  always_comb begin
    c1Tx_out       = head;
    c1Tx_out.valid = out_valid;
  end

  assign c1Tx_in_almostFull = almost_full_q;
  assign packetsReady       = packets_ready_q;

`ifdef CCI_MPF_PRIM_WRITE_PACKET_BUFFER_CHECK_EN
  t_cci_clNum pkt_len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_len_q <= '0;
    end else if (enq && in_is_write) begin
      pkt_len_q <= c1Tx_in.hdr.base.cl_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (c1Tx_in.valid && in_is_write) begin
        if (c1Tx_in.hdr.base.sop != (in_beat_q == '0))
          $fatal(1, "write_packet_buffer: sop does not match beat position");
        if (((c1Tx_in.hdr.base.address[1:0] ^ in_beat_q) & c1Tx_in.hdr.base.cl_len) != '0)
          $fatal(1, "write_packet_buffer: misaligned multi-line address");
        if ((in_beat_q != '0) && (c1Tx_in.hdr.base.cl_len != pkt_len_q))
          $fatal(1, "write_packet_buffer: cl_len changed within packet");
      end
      if (c1Tx_in.valid && full && !c1Tx_out_deq)
        $fatal(1, "write_packet_buffer: enqueue while full");
      if (c1Tx_out_deq && !out_valid)
        $fatal(1, "write_packet_buffer: dequeue while output not valid");
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_write_packet_buffer.sv
// tb/tb_cci_mpf_prim_write_packet_buffer.sv - directed self-checking bench for the write packet buffer.
module tb_cci_mpf_prim_write_packet_buffer;
  import cci_mpf_prim_write_packet_buffer_pkg::*;

  logic              clk;
  logic              reset_n;
  t_if_cci_mpf_c1_Tx c1Tx_in;
  logic              c1Tx_in_almostFull;
  t_if_cci_mpf_c1_Tx c1Tx_out;
  logic              c1Tx_out_deq;
  logic [4:0]        packetsReady;

  int n_checks = 0;
  int n_fail   = 0;

  cci_mpf_prim_write_packet_buffer #(.DEPTH(16), .ALMOST_FULL_THRESHOLD(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .c1Tx_in            (c1Tx_in),
    .c1Tx_in_almostFull (c1Tx_in_almostFull),
    .c1Tx_out           (c1Tx_out),
    .c1Tx_out_deq       (c1Tx_out_deq),
    .packetsReady       (packetsReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input t_cci_c1_req rt, input logic sop, input t_cci_clNum len,
                       input logic [41:0] addr);
    c1Tx_in.valid             = 1'b1;
    c1Tx_in.hdr.base.req_type = rt;
    c1Tx_in.hdr.base.sop      = sop;
    c1Tx_in.hdr.base.cl_len   = len;
    c1Tx_in.hdr.base.address  = addr;
    c1Tx_in.data              = 64'(addr) ^ 64'hD000;
  endtask

  task automatic idle();
    c1Tx_in.valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    c1Tx_out_deq = 1'b0;
    c1Tx_in      = '0;

    // reset state
    @(negedge clk);
    check_eq("rst_valid", 64'(c1Tx_out.valid), 64'd0);
    check_eq("rst_af", 64'(c1Tx_in_almostFull), 64'd0);
    check_eq("rst_pr", 64'(packetsReady), 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_valid", 64'(c1Tx_out.valid), 64'd0);
    check_eq("post_rst_af", 64'(c1Tx_in_almostFull), 64'd0);

    // single-line write, one-cycle latency
    c1Tx_out_deq = 1'b1;
    drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h10);
    tick();
    idle();
    check_eq("single_valid", 64'(c1Tx_out.valid), 64'd1);
    check_eq("single_addr", 64'(c1Tx_out.hdr.base.address), 64'h10);
    check_eq("single_data", c1Tx_out.data, 64'hD010);
    check_eq("single_pr1", 64'(packetsReady), 64'd1);
    tick();
    check_eq("single_gone", 64'(c1Tx_out.valid), 64'd0);
    check_eq("single_pr0", 64'(packetsReady), 64'd0);

    // non-write message completes by itself
    drive(eREQ_WRFENCE, 1'b0, 2'd0, 42'h0);
    tick();
    idle();
    check_eq("fence_valid", 64'(c1Tx_out.valid), 64'd1);
    check_eq("fence_type", 64'(c1Tx_out.hdr.base.req_type), 64'(eREQ_WRFENCE));
    check_eq("fence_pr", 64'(packetsReady), 64'd1);
    tick();
    check_eq("fence_pr0", 64'(packetsReady), 64'd0);

    // 4-line write with 2 idle cycles between beats
    for (int b = 0; b < 4; b++) begin
      drive(eREQ_WRLINE_I, (b == 0), 2'd3, 42'h40 + 42'(b));
      tick();
      idle();
      if (b < 3) begin
        check_eq("ml_hold_a", 64'(c1Tx_out.valid), 64'd0);
        tick();
        check_eq("ml_hold_b", 64'(c1Tx_out.valid), 64'd0);
        tick();
      end
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("ml_stream_valid", 64'(c1Tx_out.valid), 64'd1);
      check_eq("ml_stream_addr", 64'(c1Tx_out.hdr.base.address), 64'h40 + 64'(i));
      tick();
    end
    check_eq("ml_done_valid", 64'(c1Tx_out.valid), 64'd0);
    check_eq("ml_done_pr", 64'(packetsReady), 64'd0);

    // interleave: complete 2-line, then partial 4-line
    c1Tx_out_deq = 1'b0;
    drive(eREQ_WRLINE_M, 1'b1, 2'd1, 42'h80); tick();
    drive(eREQ_WRLINE_M, 1'b0, 2'd1, 42'h81); tick();
    drive(eREQ_WRLINE_I, 1'b1, 2'd3, 42'hC0); tick();
    drive(eREQ_WRLINE_I, 1'b0, 2'd3, 42'hC1); tick();
    idle();
    check_eq("il_pr", 64'(packetsReady), 64'd1);
    c1Tx_out_deq = 1'b1;
    check_eq("il_b0", 64'(c1Tx_out.hdr.base.address), 64'h80);
    tick();
    check_eq("il_b1_valid", 64'(c1Tx_out.valid), 64'd1);
    check_eq("il_b1", 64'(c1Tx_out.hdr.base.address), 64'h81);
    tick();
    check_eq("il_stall_a", 64'(c1Tx_out.valid), 64'd0);
    tick();
    check_eq("il_stall_b", 64'(c1Tx_out.valid), 64'd0);
    drive(eREQ_WRLINE_I, 1'b0, 2'd3, 42'hC2); tick();
    check_eq("il_stall_c", 64'(c1Tx_out.valid), 64'd0);
    drive(eREQ_WRLINE_I, 1'b0, 2'd3, 42'hC3); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      check_eq("il_tail_valid", 64'(c1Tx_out.valid), 64'd1);
      check_eq("il_tail_addr", 64'(c1Tx_out.hdr.base.address), 64'hC0 + 64'(i));
      tick();
    end
    check_eq("il_end_valid", 64'(c1Tx_out.valid), 64'd0);

    // fill to DEPTH with single-line writes
    c1Tx_out_deq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h100 + 42'(i));
      tick();
      if (i == 10) check_eq("af_at_11", 64'(c1Tx_in_almostFull), 64'd0);
      if (i == 11) check_eq("af_at_12", 64'(c1Tx_in_almostFull), 64'd1);
    end
    idle();
    check_eq("full_af", 64'(c1Tx_in_almostFull), 64'd1);
    check_eq("full_pr", 64'(packetsReady), 64'd16);
    drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h1FF);
    tick();
    idle();
    check_eq("drop_pr", 64'(packetsReady), 64'd16);
    check_eq("drop_head", 64'(c1Tx_out.hdr.base.address), 64'h100);
    c1Tx_out_deq = 1'b1;
    drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h110);
    tick();
    idle();
    check_eq("full_swap_pr", 64'(packetsReady), 64'd16);
    check_eq("full_swap_af", 64'(c1Tx_in_almostFull), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      check_eq("drain_addr", 64'(c1Tx_out.hdr.base.address), 64'h100 + 64'(i));
      tick();
    end
    check_eq("drain_valid", 64'(c1Tx_out.valid), 64'd0);
    check_eq("drain_af", 64'(c1Tx_in_almostFull), 64'd0);

    // reset mid-packet
    c1Tx_out_deq = 1'b0;
    drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h1F0); tick();
    drive(eREQ_WRLINE_I, 1'b1, 2'd3, 42'h200); tick();
    drive(eREQ_WRLINE_I, 1'b0, 2'd3, 42'h201); tick();
    idle();
    check_eq("pre_rst_pr", 64'(packetsReady), 64'd1);
    check_eq("pre_rst_valid", 64'(c1Tx_out.valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(c1Tx_out.valid), 64'd0);
    check_eq("mid_rst_af", 64'(c1Tx_in_almostFull), 64'd0);
    check_eq("mid_rst_pr", 64'(packetsReady), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("rel_valid", 64'(c1Tx_out.valid), 64'd0);
    c1Tx_out_deq = 1'b1;
    drive(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h300);
    tick();
    idle();
    check_eq("fresh_valid", 64'(c1Tx_out.valid), 64'd1);
    check_eq("fresh_addr", 64'(c1Tx_out.hdr.base.address), 64'h300);
    check_eq("fresh_pr", 64'(packetsReady), 64'd1);
    tick();
    check_eq("fresh_gone", 64'(c1Tx_out.valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
